// File: rtl/ddr_pkg.sv
// ddr_pkg: shared types and default widths for the DDR channel arbiter
package ddr_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} ddr_state_e;
  typedef enum logic {CH_IFU, CH_LSU} ddr_chan_e;
  localparam int DEF_ADDR_W = 64;
  localparam int DEF_LINE_W = 512;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker, bit 0 = IFU, bit 1 = LSU, one-hot grant
module rr_arb2
  import ddr_pkg::*;
(
  input  logic [1:0] req,
  input  ddr_chan_e  last_grant,
  output logic [1:0] grant
);
  assign grant[0] = req[0] & (~req[1] | (last_grant == CH_LSU));
  assign grant[1] = req[1] & (~req[0] | (last_grant == CH_IFU));
endmodule

// File: rtl/ddr_channel_arbiter.sv
// ddr_channel_arbiter: shares one simddr command port between IFU refills and LSU accesses
module ddr_channel_arbiter
  import ddr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_index,
  output logic              ifu_resp_valid,
  output logic [LINE_W-1:0] ifu_resp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_index,
  input  logic              lsu_req_write,
  input  logic [LINE_W-1:0] lsu_req_wmask,
  input  logic [LINE_W-1:0] lsu_req_wdata,
  output logic              lsu_resp_valid,
  output logic [LINE_W-1:0] lsu_resp_data,
  output logic              ddr_chip_enable,
  output logic [ADDR_W-1:0] ddr_index,
  output logic              ddr_write_enable,
  output logic              ddr_burst_mode,
  output logic [LINE_W-1:0] ddr_write_mask,
  output logic [LINE_W-1:0] ddr_write_data,
  input  logic [LINE_W-1:0] ddr_read_data,
  input  logic              ddr_operation_done,
  input  logic              ddr_ready
);
  ddr_state_e state;
  ddr_chan_e  last_grant, owner, pick;
  logic [1:0] grant;
  logic       accept;

  rr_arb2 u_arb (
    .req        ({lsu_req_valid, ifu_req_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign accept        = (state == IDLE) & ddr_ready & |grant;
  assign ifu_req_ready = accept & grant[0];
  assign lsu_req_ready = accept & grant[1];
  assign pick          = grant[1] ? CH_LSU : CH_IFU;

  // One transaction at a time: grant, strobe the command, wait for DDR, return the line
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      last_grant       <= CH_IFU;
      owner            <= CH_IFU;
      ddr_chip_enable  <= 1'b0;
      ddr_index        <= '0;
      ddr_write_enable <= 1'b0;
      ddr_burst_mode   <= 1'b0;
      ddr_write_mask   <= '0;
      ddr_write_data   <= '0;
      ifu_resp_valid   <= 1'b0;
      lsu_resp_valid   <= 1'b0;
      ifu_resp_data    <= '0;
      lsu_resp_data    <= '0;
    end else begin
      ddr_chip_enable <= 1'b0;
      ifu_resp_valid  <= 1'b0;
      lsu_resp_valid  <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state            <= ISSUE;
          ddr_chip_enable  <= 1'b1;
          owner            <= pick;
          last_grant       <= pick;
          ddr_index        <= grant[1] ? lsu_req_index : ifu_req_index;
          ddr_write_enable <= grant[1] & lsu_req_write;
          ddr_burst_mode   <= grant[0];
          ddr_write_mask   <= grant[1] ? lsu_req_wmask : '0;
          ddr_write_data   <= grant[1] ? lsu_req_wdata : '0;
        end
        ISSUE: state <= WAIT;
        WAIT: if (ddr_operation_done) begin
          state <= RESP;
          if (owner == CH_LSU) begin
            lsu_resp_data  <= ddr_read_data;
            lsu_resp_valid <= 1'b1;
          end else begin
            ifu_resp_data  <= ddr_read_data;
            ifu_resp_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
